scan_raster_gen: RTL and testbench
==================================

// Module: scan_raster_gen
// PURPOSE
//  Parametrised galvo scan-pattern generator feeding the XY2-100 sender: point, unidirectional
//  raster or serpentine raster between programmable X/Y limits, with per-point dwell and multi-frame
//  repeat. Computes pixel steps internally with a sequential divider. Drives coordinates to the
//  sender over a valid/ready handshake.
// PARAMETERS
//  COORD_W  16  coordinate / limit width
//  CNT_W    16  pixel-count width (nx, ny, x_idx, y_idx)
//  DWELL_W  32  dwell counter width
//  FRM_W    8   frame-repeat counter width
// PORTS
//  clk          in   1        system clock
//  reset_n      in   1        asynchronous reset, active low
//  start        in   1        1-cycle start request; sampled only in IDLE
//  abort        in   1        stop scan immediately
//  mode         in   2        0 point, 1 raster-uni, 2 raster-serpentine, 3 = point
//  nx, ny       in   CNT_W    points per line / lines per frame (>=1)
//  x_min,x_max  in   COORD_W  X limits, inclusive
//  y_min,y_max  in   COORD_W  Y limits, inclusive
//  dwell        in   DWELL_W  cycles to hold after each accepted point (0 = none)
//  frames       in   FRM_W    frame count; 0 = continuous until abort
//  x_coord      out  COORD_W  X coordinate, stable while coord_valid
//  y_coord      out  COORD_W  Y coordinate, stable while coord_valid
//  coord_valid  out  1        coordinate offered to sender
//  coord_ready  in   1        sender accepts; transfer = valid & ready
//  x_idx, y_idx out  CNT_W    index of the current point
//  line_start   out  1        current point is first of its line (qualified by coord_valid)
//  frame_start  out  1        current point is (0,0) of a frame (qualified by coord_valid)
//  busy         out  1        high in every state except IDLE
//  done         out  1        1-cycle pulse: all frames completed
//  cfg_err      out  1        1-cycle pulse: start rejected
// BEHAVIOUR
//  Reset: every output 0. State = IDLE. All counters 0.
//  Config is latched on the accepted start. Later input changes have no effect until the next start.
//  Rejection: cfg_err pulses the cycle after start and the block stays IDLE if any of:
//   nx==0, ny==0, x_max<x_min, y_max<y_min.
//  Point mode ignores nx/ny (1 point at x_min,y_min per frame).
//  Start while busy is ignored.
//  FSM: IDLE -> CALC -> EMIT -> DWELL -> (EMIT | DONE) -> IDLE.
//   CALC: restoring dividers, X and Y in parallel, exactly COORD_W cycles.
//    dx = (x_max-x_min)/(nx-1), and dx = 0 when nx==1.
//    dy = (y_max-y_min)/(ny-1), and dy = 0 when ny==1.
//    The quotient is floored.
//   EMIT: coord_valid=1 and all outputs held until coord_ready. On transfer go to DWELL.
//   DWELL: count dwell cycles. dwell==0 means 1 cycle in DWELL. Then advance the index and
//    return to EMIT (valid re-asserts the next cycle), or go to DONE after the last point.
//  Latency: first coord_valid is asserted COORD_W+1 cycles after the start cycle.
//  Coordinates use a COORD_W+1 accumulator. x = x_min + x_idx*dx, except the last point of a
//   line, which is exactly x_max (clamp absorbs the floor error). Y uses the same rule.
//   Overflow is impossible by construction.
//  Raster-uni: every line runs x_min..x_max.
//  Serpentine: even y_idx runs min->max, odd y_idx runs max->min. x_idx always counts 0..nx-1
//   in emission order.
//  Frame end: y_idx and x_idx return to 0 and the frame counter increments. Each frame restarts
//   at (x_min,y_min) regardless of serpentine parity.
//   frames==0 repeats forever. Otherwise DONE is entered after frame number `frames`.
//  DONE: done pulses for 1 cycle, busy drops with it, return to IDLE.
//  abort: from any state, next cycle is IDLE with coord_valid=0, busy=0, no done.
//   A transfer in the abort cycle is discarded. abort and start together: abort wins.
//  coord_ready while coord_valid=0 is ignored.
//  reset_n low mid-scan: immediate return to reset values.
// TESTING
//  T1 point: mode0, x_min=100,y_min=200, dwell=5, frames=1, ready=1.
//   -> one transfer (100,200); done 7 cycles after the transfer.
//  T2 uni: mode1, nx=3,ny=2, x 0..10, y 0..4.
//   -> (0,0)(5,0)(10,0)(0,4)(5,4)(10,4); line_start on idx0 of each line.
//  T3 serpentine clamp: mode2, nx=4,ny=3, x 0..10, y 0..9.
//   -> dx=3; X sequence 0,3,6,10 | 10,7,4,0 | 0,3,6,10; Y values 0,4,9 (y_max clamped).
//  T4 backpressure: ready low 20 cycles during EMIT -> x/y/idx stable, single transfer, no skipped point.
//  T5 abort/repeat: frames=0, abort in DWELL of frame 3 -> IDLE next cycle, no done;
//   frames=2 -> exactly 2 frame_start transfers, then done.
//  T6 errors: nx=0, or x_max<x_min -> cfg_err pulse, busy stays 0; start while busy -> ignored.

Source files
------------

// File: rtl/scan_raster_gen.sv
// Galvo scan-pattern generator: point, unidirectional raster or serpentine raster between
// programmable limits, with per-point dwell and frame repeat. Pixel steps come from two
// restoring dividers run in parallel; coordinates leave over a valid/ready handshake.
module scan_raster_gen #(
  parameter int unsigned COORD_W = 16,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned DWELL_W = 32,
  parameter int unsigned FRM_W   = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         mode,
  input  logic [CNT_W-1:0]   nx,
  input  logic [CNT_W-1:0]   ny,
  input  logic [COORD_W-1:0] x_min,
  input  logic [COORD_W-1:0] x_max,
  input  logic [COORD_W-1:0] y_min,
  input  logic [COORD_W-1:0] y_max,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [FRM_W-1:0]   frames,
  output logic [COORD_W-1:0] x_coord,
  output logic [COORD_W-1:0] y_coord,
  output logic               coord_valid,
  input  logic               coord_ready,
  output logic [CNT_W-1:0]   x_idx,
  output logic [CNT_W-1:0]   y_idx,
  output logic               line_start,
  output logic               frame_start,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  localparam int unsigned CalcW = $clog2(COORD_W) + 1;

  typedef enum logic [2:0] {StIdle, StCalc, StEmit, StDwell, StDone} state_e;

  state_e               state_q, state_d;
  logic                 serp_q, serp_d;
  logic [CNT_W-1:0]     nx_q, nx_d, ny_q, ny_d;
  logic [COORD_W-1:0]   x_min_q, x_min_d, x_max_q, x_max_d;
  logic [COORD_W-1:0]   y_min_q, y_min_d, y_max_q, y_max_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d, dwell_cnt_q, dwell_cnt_d;
  logic [FRM_W-1:0]     frames_q, frames_d, frame_cnt_q, frame_cnt_d;
  logic [CalcW-1:0]     calc_cnt_q, calc_cnt_d;
  logic [COORD_W-1:0]   x_quo_q, x_quo_d, y_quo_q, y_quo_d;
  logic [CNT_W-1:0]     x_rem_q, x_rem_d, y_rem_q, y_rem_d;
  logic [COORD_W-1:0]   x_pos_q, x_pos_d, y_pos_q, y_pos_d;
  logic [CNT_W-1:0]     x_idx_q, x_idx_d, y_idx_q, y_idx_d;
  logic                 done_q, done_d, cfg_err_q, cfg_err_d;

  logic                 point_mode, cfg_bad, dwell_last;
  logic [COORD_W-1:0]   dx, dy;
  logic [DWELL_W:0]     dwell_nxt;

  // One restoring-division step; returns {remainder, shifted quotient}.
  function automatic logic [CNT_W+COORD_W-1:0] div_step(input logic [COORD_W-1:0] quo,
                                                        input logic [CNT_W-1:0]   rem,
                                                        input logic [CNT_W-1:0]   dvs);
    logic [CNT_W:0] sh;
    logic           qb;
    sh = {rem, quo[COORD_W-1]};
    qb = (sh >= {1'b0, dvs});
    if (qb) sh = sh - {1'b0, dvs};
    return {sh[CNT_W-1:0], quo[COORD_W-2:0], qb};
  endfunction

  // Coordinate of point idx on a line; the last point is clamped to the far limit so the
  // floored step never leaves it short.
  function automatic logic [COORD_W-1:0] step_coord(input logic [CNT_W-1:0]   idx,
                                                    input logic [CNT_W-1:0]   n,
                                                    input logic [COORD_W-1:0] lo,
                                                    input logic [COORD_W-1:0] hi,
                                                    input logic [COORD_W-1:0] d,
                                                    input logic [COORD_W-1:0] cur,
                                                    input logic               rev);
    logic [COORD_W:0] acc;
    if (idx == n - CNT_W'(1)) return rev ? lo : hi;
    if (idx == '0) return rev ? hi : lo;
    acc = rev ? ({1'b0, cur} - {1'b0, d}) : ({1'b0, cur} + {1'b0, d});
    if (acc[COORD_W]) return rev ? lo : hi;
    return acc[COORD_W-1:0];
  endfunction

  assign point_mode = (mode == 2'd0) || (mode == 2'd3);
  assign cfg_bad    = (!point_mode && ((nx == '0) || (ny == '0))) ||
                      (x_max < x_min) || (y_max < y_min);
  assign dx         = (nx_q == CNT_W'(1)) ? '0 : x_quo_q;
  assign dy         = (ny_q == CNT_W'(1)) ? '0 : y_quo_q;
  assign dwell_nxt  = {1'b0, dwell_cnt_q} + {{DWELL_W{1'b0}}, 1'b1};
  assign dwell_last = (dwell_nxt >= {1'b0, dwell_q});

  // Next-state: config latch, division, emission and index advance; abort overrides all.
  always_comb begin
    state_d     = state_q;
    serp_d      = serp_q;
    nx_d        = nx_q;
    ny_d        = ny_q;
    x_min_d     = x_min_q;
    x_max_d     = x_max_q;
    y_min_d     = y_min_q;
    y_max_d     = y_max_q;
    dwell_d     = dwell_q;
    frames_d    = frames_q;
    dwell_cnt_d = dwell_cnt_q;
    frame_cnt_d = frame_cnt_q;
    calc_cnt_d  = calc_cnt_q;
    x_quo_d     = x_quo_q;
    y_quo_d     = y_quo_q;
    x_rem_d     = x_rem_q;
    y_rem_d     = y_rem_q;
    x_pos_d     = x_pos_q;
    y_pos_d     = y_pos_q;
    x_idx_d     = x_idx_q;
    y_idx_d     = y_idx_q;
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (cfg_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            state_d     = StCalc;
            serp_d      = (mode == 2'd2);
            // Point mode collapses to a single-point grid at (x_min, y_min).
            nx_d        = point_mode ? CNT_W'(1) : nx;
            ny_d        = point_mode ? CNT_W'(1) : ny;
            x_min_d     = x_min;
            x_max_d     = point_mode ? x_min : x_max;
            y_min_d     = y_min;
            y_max_d     = point_mode ? y_min : y_max;
            dwell_d     = dwell;
            frames_d    = frames;
            frame_cnt_d = '0;
            calc_cnt_d  = '0;
            x_quo_d     = point_mode ? '0 : x_max - x_min;
            y_quo_d     = point_mode ? '0 : y_max - y_min;
            x_rem_d     = '0;
            y_rem_d     = '0;
            x_idx_d     = '0;
            y_idx_d     = '0;
          end
        end
      end
      StCalc: begin
        {x_rem_d, x_quo_d} = div_step(x_quo_q, x_rem_q, nx_q - CNT_W'(1));
        {y_rem_d, y_quo_d} = div_step(y_quo_q, y_rem_q, ny_q - CNT_W'(1));
        calc_cnt_d = calc_cnt_q + CalcW'(1);
        if (calc_cnt_q == CalcW'(COORD_W - 1)) begin
          state_d = StEmit;
          x_pos_d = step_coord('0, nx_q, x_min_q, x_max_q, dx, x_pos_q, 1'b0);
          y_pos_d = step_coord('0, ny_q, y_min_q, y_max_q, dy, y_pos_q, 1'b0);
        end
      end
      StEmit: begin
        if (coord_ready) begin
          state_d     = StDwell;
          dwell_cnt_d = '0;
        end
      end
      StDwell: begin
        dwell_cnt_d = dwell_nxt[DWELL_W-1:0];
        if (dwell_last) begin
          state_d = StEmit;
          if (x_idx_q != nx_q - CNT_W'(1)) begin
            x_idx_d = x_idx_q + CNT_W'(1);
            x_pos_d = step_coord(x_idx_q + CNT_W'(1), nx_q, x_min_q, x_max_q, dx, x_pos_q,
                                 serp_q & y_idx_q[0]);
          end else if (y_idx_q != ny_q - CNT_W'(1)) begin
            x_idx_d = '0;
            y_idx_d = y_idx_q + CNT_W'(1);
            x_pos_d = step_coord('0, nx_q, x_min_q, x_max_q, dx, x_pos_q,
                                 serp_q & ~y_idx_q[0]);
            y_pos_d = step_coord(y_idx_q + CNT_W'(1), ny_q, y_min_q, y_max_q, dy, y_pos_q,
                                 1'b0);
          end else if ((frames_q != '0) && (frame_cnt_q + FRM_W'(1) == frames_q)) begin
            state_d = StDone;
          end else begin
            // New frame always restarts forward at (x_min, y_min).
            frame_cnt_d = frame_cnt_q + FRM_W'(1);
            x_idx_d     = '0;
            y_idx_d     = '0;
            x_pos_d     = step_coord('0, nx_q, x_min_q, x_max_q, dx, x_pos_q, 1'b0);
            y_pos_d     = step_coord('0, ny_q, y_min_q, y_max_q, dy, y_pos_q, 1'b0);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (abort) begin
      state_d   = StIdle;
      done_d    = 1'b0;
      cfg_err_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      serp_q      <= 1'b0;
      nx_q        <= '0;
      ny_q        <= '0;
      x_min_q     <= '0;
      x_max_q     <= '0;
      y_min_q     <= '0;
      y_max_q     <= '0;
      dwell_q     <= '0;
      frames_q    <= '0;
      dwell_cnt_q <= '0;
      frame_cnt_q <= '0;
      calc_cnt_q  <= '0;
      x_quo_q     <= '0;
      y_quo_q     <= '0;
      x_rem_q     <= '0;
      y_rem_q     <= '0;
      x_pos_q     <= '0;
      y_pos_q     <= '0;
      x_idx_q     <= '0;
      y_idx_q     <= '0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      serp_q      <= serp_d;
      nx_q        <= nx_d;
      ny_q        <= ny_d;
      x_min_q     <= x_min_d;
      x_max_q     <= x_max_d;
      y_min_q     <= y_min_d;
      y_max_q     <= y_max_d;
      dwell_q     <= dwell_d;
      frames_q    <= frames_d;
      dwell_cnt_q <= dwell_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      calc_cnt_q  <= calc_cnt_d;
      x_quo_q     <= x_quo_d;
      y_quo_q     <= y_quo_d;
      x_rem_q     <= x_rem_d;
      y_rem_q     <= y_rem_d;
      x_pos_q     <= x_pos_d;
      y_pos_q     <= y_pos_d;
      x_idx_q     <= x_idx_d;
      y_idx_q     <= y_idx_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  // Output decode.
  always_comb begin
    coord_valid = (state_q == StEmit);
    busy        = (state_q != StIdle);
    x_coord     = x_pos_q;
    y_coord     = y_pos_q;
    x_idx       = x_idx_q;
    y_idx       = y_idx_q;
    line_start  = coord_valid && (x_idx_q == '0);
    frame_start = line_start && (y_idx_q == '0);
    done        = done_q;
    cfg_err     = cfg_err_q;
  end

endmodule

// File: tb/tb_scan_raster_gen.sv
// Scoreboard bench for scan_raster_gen: a reference model enqueues the expected point stream
// per scan, a monitor pops and compares on every transfer.
module tb_scan_raster_gen;

  logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [1:0]  mode = '0;
  logic [15:0] nx = '0, ny = '0, x_min = '0, x_max = '0, y_min = '0, y_max = '0;
  logic [31:0] dwell = '0;
  logic [7:0]  frames = '0;
  logic        coord_ready = 1'b0;
  logic [15:0] x_coord, y_coord, x_idx, y_idx;
  logic        coord_valid, line_start, frame_start, busy, done, cfg_err;

  scan_raster_gen #(.COORD_W(16), .CNT_W(16), .DWELL_W(32), .FRM_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .mode(mode),
    .nx(nx), .ny(ny), .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
    .dwell(dwell), .frames(frames), .x_coord(x_coord), .y_coord(y_coord),
    .coord_valid(coord_valid), .coord_ready(coord_ready), .x_idx(x_idx), .y_idx(y_idx),
    .line_start(line_start), .frame_start(frame_start), .busy(busy), .done(done),
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] x, y, xi, yi;
    logic        ls, fs;
  } exp_t;

  exp_t exp_q[$];
  int cyc = 0, n_cmp = 0, n_bad = 0;
  int n_done = 0, n_err = 0, n_fs = 0, n_xfer = 0;
  int done_cyc = 0, last_xfer_cyc = 0, first_valid_cyc = -1;
  int ready_pct = 100, stall_left = 0;
  logic        prev_stall = 1'b0;
  logic [15:0] px, py, pxi, pyi;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Ready driver: random acceptance, with an optional forced stall window.
  initial forever begin
    @(posedge clk); #1;
    if (stall_left > 0) begin
      coord_ready = 1'b0;
      stall_left--;
    end else begin
      coord_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // Monitor: scoreboard pop on transfer, hold check under backpressure, event counters.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (prev_stall) begin
        check("hold_coord", {31'd0, coord_valid, x_coord, y_coord}, {31'd0, 1'b1, px, py});
        check("hold_idx", {x_idx, y_idx}, {pxi, pyi});
      end
      prev_stall = coord_valid && !coord_ready && !abort;
      px = x_coord; py = y_coord; pxi = x_idx; pyi = y_idx;
      if (coord_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (coord_valid && coord_ready) begin
        if (exp_q.size() == 0) begin
          check("xfer_unexpected", {x_coord, y_coord}, 64'hffff_ffff_ffff_ffff);
        end else begin
          e = exp_q.pop_front();
          check("xfer_coord", {x_coord, y_coord}, {e.x, e.y});
          check("xfer_idx_flags", {x_idx, y_idx, line_start, frame_start},
                {e.xi, e.yi, e.ls, e.fs});
        end
        n_xfer++;
        last_xfer_cyc = cyc;
        if (frame_start) n_fs++;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (cfg_err) n_err++;
    end
  end

  // Reference model: expected point stream computed directly from the scan rules.
  task automatic push_model(input int m, input int nxv, input int nyv, input int xa,
                            input int xb, input int ya, input int yb, input int nfr);
    int dx, dy, x, y;
    bit rev;
    dx = (nxv == 1) ? 0 : (xb - xa) / (nxv - 1);
    dy = (nyv == 1) ? 0 : (yb - ya) / (nyv - 1);
    for (int f = 0; f < nfr; f++) begin
      if (m == 0 || m == 3) begin
        exp_q.push_back(exp_t'{16'(xa), 16'(ya), 16'd0, 16'd0, 1'b1, 1'b1});
      end else begin
        for (int yi = 0; yi < nyv; yi++) begin
          for (int xi = 0; xi < nxv; xi++) begin
            rev = (m == 2) && (yi % 2 == 1);
            if (xi == nxv - 1) x = rev ? xa : xb;
            else               x = rev ? xb - xi * dx : xa + xi * dx;
            y = (yi == nyv - 1) ? yb : ya + yi * dy;
            exp_q.push_back(exp_t'{16'(x), 16'(y), 16'(xi), 16'(yi), xi == 0,
                                   (xi == 0) && (yi == 0)});
          end
        end
      end
    end
  endtask

  task automatic run_scan(input int m, input int nxv, input int nyv, input int xa, input int xb,
                          input int ya, input int yb, input int dw, input int fr,
                          input int rdy, input bit mid_start);
    int sc, budget, d0, e0, fs0;
    push_model(m, nxv, nyv, xa, xb, ya, yb, fr);
    ready_pct = rdy;
    d0 = n_done; e0 = n_err; fs0 = n_fs;
    @(posedge clk); #1;
    first_valid_cyc = -1;
    mode = 2'(m); nx = 16'(nxv); ny = 16'(nyv); x_min = 16'(xa); x_max = 16'(xb);
    y_min = 16'(ya); y_max = 16'(yb); dwell = 32'(dw); frames = 8'(fr); start = 1'b1;
    sc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    // Latched config must ignore later input changes.
    mode = 2'($urandom); nx = 16'($urandom); ny = 16'($urandom); x_min = 16'($urandom);
    x_max = 16'($urandom); y_min = 16'($urandom); dwell = $urandom; frames = 8'($urandom);
    if (mid_start) begin
      repeat (25) @(posedge clk);
      #1; nx = 16'd0; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
    end
    budget = 20000;
    while (n_done == d0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #1;
    check("done_seen", 64'(n_done - d0), 64'd1);
    check("first_valid_latency", 64'(first_valid_cyc - sc), 64'd17);
    check("done_after_last_xfer", 64'(done_cyc - last_xfer_cyc), 64'((dw == 0 ? 1 : dw) + 2));
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("no_cfg_err", 64'(n_err - e0), 64'd0);
    check("frame_starts", 64'(n_fs - fs0), 64'(fr));
    check("idle_after_done", {61'd0, busy, coord_valid, done}, 64'd0);
    exp_q.delete();
  endtask

  task automatic run_bad(input int nxv, input int xa, input int xb);
    @(posedge clk); #1;
    mode = 2'd1; nx = 16'(nxv); ny = 16'd2; x_min = 16'(xa); x_max = 16'(xb);
    y_min = 16'd0; y_max = 16'd5; dwell = 32'd0; frames = 8'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("cfg_err_pulse", {63'd0, cfg_err}, 64'd1);
    check("cfg_err_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    check("cfg_err_one_cycle", {62'd0, cfg_err, busy}, 64'd0);
  endtask

  task automatic run_abort();
    int budget, fs0, d0, x0;
    fs0 = n_fs; d0 = n_done;
    push_model(1, 2, 2, 10, 50, 20, 40, 3);
    ready_pct = 100;
    @(posedge clk); #1;
    mode = 2'd1; nx = 16'd2; ny = 16'd2; x_min = 16'd10; x_max = 16'd50;
    y_min = 16'd20; y_max = 16'd40; dwell = 32'd3; frames = 8'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    budget = 5000;
    while (n_fs - fs0 < 3 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    check("abort_reached_frame3", 64'(n_fs - fs0), 64'd3);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_idle", {61'd0, busy, coord_valid, done}, 64'd0);
    x0 = n_xfer;
    repeat (30) @(negedge clk);
    check("abort_no_done", 64'(n_done - d0), 64'd0);
    check("abort_no_xfer", 64'(n_xfer - x0), 64'd0);
    check("abort_residue", 64'(exp_q.size()), 64'd3);
    exp_q.delete();
  endtask

  initial begin
    int m, a, b, c, d;
    repeat (3) @(negedge clk);
    check("reset_coords", {x_coord, y_coord, x_idx, y_idx}, 64'd0);
    check("reset_flags", {58'd0, coord_valid, line_start, frame_start, busy, done, cfg_err},
          64'd0);
    @(posedge clk); #1 reset_n = 1'b1;

    run_scan(0, 7, 9, 100, 300, 200, 400, 5, 1, 100, 1'b0);   // point
    run_scan(1, 3, 2, 0, 10, 0, 4, 0, 1, 100, 1'b0);          // raster-uni
    run_scan(2, 4, 3, 0, 10, 0, 9, 1, 1, 70, 1'b0);           // serpentine with clamp
    stall_left = 37;                                          // ~20 stalled cycles in EMIT
    run_scan(1, 3, 2, 5, 100, 7, 70, 2, 1, 100, 1'b0);
    run_abort();
    run_scan(2, 2, 2, 0, 1000, 0, 500, 0, 2, 100, 1'b0);      // two frames
    run_bad(0, 0, 10);
    run_bad(3, 20, 10);
    // abort and start together: abort wins
    @(posedge clk); #1;
    mode = 2'd1; nx = 16'd2; ny = 16'd2; x_min = 16'd0; x_max = 16'd9;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("abort_beats_start", {62'd0, busy, cfg_err}, 64'd0);
    run_scan(2, 4, 3, 0, 10, 0, 9, 2, 1, 100, 1'b1);          // start while busy ignored

    for (int i = 0; i < 12; i++) begin
      m = $urandom_range(0, 3);
      a = $urandom_range(0, 60000);
      b = a + $urandom_range(0, 65535 - a);
      c = $urandom_range(0, 60000);
      d = c + $urandom_range(0, 65535 - c);
      run_scan(m, $urandom_range(1, 5), $urandom_range(1, 4), a, b, c, d,
               $urandom_range(0, 3), $urandom_range(1, 2), $urandom_range(40, 100), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
